// File: rtl/fpu_stack_pkg.sv
// fpu_stack_pkg
// Shared definitions for the x87-style FPU register stack:
//   - op_code encodings accepted by fpu_reg_stack
//   - 2-bit register tag encodings
//   - default QNaN indefinite value written on stack faults
//   - sequencer state type
//   - tag classification helper used by fpu_tag_classify
package fpu_stack_pkg;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_PUSH      = 4'd1;
  localparam logic [3:0] OP_POP       = 4'd2;
  localparam logic [3:0] OP_REPL_PUSH = 4'd3;
  localparam logic [3:0] OP_WRITE     = 4'd4;
  localparam logic [3:0] OP_WRITE_POP = 4'd5;
  localparam logic [3:0] OP_XCH       = 4'd6;
  localparam logic [3:0] OP_FREE      = 4'd7;
  localparam logic [3:0] OP_INIT      = 4'd8;
  localparam logic [3:0] OP_INC_TOP   = 4'd9;
  localparam logic [3:0] OP_DEC_TOP   = 4'd10;

  localparam logic [1:0] TAG_VALID   = 2'b00;
  localparam logic [1:0] TAG_ZERO    = 2'b01;
  localparam logic [1:0] TAG_SPECIAL = 2'b10;
  localparam logic [1:0] TAG_EMPTY   = 2'b11;

  // Sign=1, exponent all ones, mantissa 1100...0: the x87 QNaN indefinite.
  localparam logic [79:0] INDEF_DEFAULT = 80'hFFFF_C000_0000_0000_0000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REPL2 = 1'b1
  } stack_state_e;

  // All-ones exponent is a NaN/infinity; a zero exponent is either a true
  // zero or (with a non-zero mantissa) a denormal, which counts as special.
  function automatic logic [1:0] classify_tag(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic man_zero);
    logic [1:0] tag;
    if (exp_ones) begin
      tag = TAG_SPECIAL;
    end else if (exp_zero) begin
      tag = man_zero ? TAG_ZERO : TAG_SPECIAL;
    end else begin
      tag = TAG_VALID;
    end
    return tag;
  endfunction

endpackage

// File: rtl/fpu_tag_classify.sv
// fpu_tag_classify
// Combinational tag generator for a value about to be written into the
// register stack.
// Ports:
//   value  in  WIDTH  sign | exponent (EXP_W) | mantissa (MAN_W)
//   tag    out 2      00 valid, 01 zero, 10 special (never 11 here)
module fpu_tag_classify
  import fpu_stack_pkg::*;
#(
  parameter int EXP_W = 15,
  parameter int MAN_W = 64,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic [WIDTH-1:0] value,
  output logic [1:0]       tag
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;
  logic             unused_sign;

  assign exp_field   = value[WIDTH-2 -: EXP_W];
  assign man_field   = value[MAN_W-1:0];
  // The sign never affects the tag.
  assign unused_sign = value[WIDTH-1];

  assign tag = classify_tag(exp_field == '0, &exp_field, man_field == '0);

endmodule

// File: rtl/fpu_reg_stack.sv
// fpu_reg_stack
// x87-style register stack: DEPTH registers of WIDTH bits, a TOP pointer and
// a 2-bit tag per physical register. ST(i) lives in physical register
// (top+i) mod DEPTH. DEPTH must be a power of two and at least 4 so that the
// pointer wraps naturally.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   op_valid/op_ready request handshake; op_ready drops in REPL_PUSH cycle 2
//   op_code, op_index operation and relative index i
//   data_a, data_b    operands (data_b is the value pushed by REPL_PUSH)
//   clear_fault       clears stack_fault/c1 (a same-cycle fault wins)
//   done              one-cycle pulse after each op completes
//   rd_index/rd_data  registered read of ST(rd_index), pre-write contents
//   st0, st1          combinational ST(0), ST(1)
//   top, tag_word     stack pointer; tags by physical register, reg 0 in [1:0]
//   stack_fault, c1   sticky fault flag; c1 = 1 overflow, 0 underflow
module fpu_reg_stack
  import fpu_stack_pkg::*;
#(
  parameter int          EXP_W = 15,
  parameter int          MAN_W = 64,
  parameter int          DEPTH = 8,
  parameter logic [79:0] INDEF = INDEF_DEFAULT,
  localparam int         WIDTH = 1 + EXP_W + MAN_W,
  localparam int         PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [3:0]         op_code,
  input  logic [PTR_W-1:0]   op_index,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  input  logic               clear_fault,
  output logic               op_ready,
  output logic               done,
  input  logic [PTR_W-1:0]   rd_index,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   st0,
  output logic [WIDTH-1:0]   st1,
  output logic [PTR_W-1:0]   top,
  output logic [2*DEPTH-1:0] tag_word,
  output logic               stack_fault,
  output logic               c1
);

  localparam logic [WIDTH-1:0] INDEF_W = WIDTH'(INDEF);

  stack_state_e     state_q, state_nxt;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [1:0]       tags [DEPTH];

  logic [PTR_W-1:0] top_q, top_nxt;
  logic [PTR_W-1:0] phys_i, push_phys, st1_phys, rd_phys;
  logic [PTR_W-1:0] wr_phys, free_phys;
  logic [WIDTH-1:0] wr_data, data_b_q, rd_q;
  logic [1:0]       wr_tag;
  logic             wr_en, free_en, xch_en, init_en;
  logic             fault_set, fault_ovf, done_nxt, latch_b;
  logic             done_q, fault_q, c1_q;

  assign phys_i    = top_q + op_index;
  assign push_phys = top_q - PTR_W'(1);
  assign st1_phys  = top_q + PTR_W'(1);
  assign rd_phys   = top_q + rd_index;

  // Every register write (including INDEF substitution) is tagged from the
  // value actually written; XCH moves existing tags instead.
  fpu_tag_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_tag_classify (
    .value (wr_data),
    .tag   (wr_tag)
  );

  // Decode the current op into a single write port, a tag-free port, an
  // exchange strobe and the next pointer/state. Fault detection looks at
  // the tags as they are before this cycle's updates.
  always_comb begin
    state_nxt = state_q;
    top_nxt   = top_q;
    wr_en     = 1'b0;
    wr_phys   = top_q;
    wr_data   = data_a;
    free_en   = 1'b0;
    free_phys = top_q;
    xch_en    = 1'b0;
    init_en   = 1'b0;
    fault_set = 1'b0;
    fault_ovf = 1'b0;
    done_nxt  = 1'b0;
    latch_b   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          done_nxt = 1'b1;
          case (op_code)
            OP_NOP: begin
            end
            OP_PUSH: begin
              wr_en   = 1'b1;
              wr_phys = push_phys;
              top_nxt = push_phys;
              if (tags[push_phys] != TAG_EMPTY) begin
                wr_data   = INDEF_W;
                fault_set = 1'b1;
                fault_ovf = 1'b1;
              end
            end
            OP_POP: begin
              free_en   = 1'b1;
              free_phys = top_q;
              top_nxt   = st1_phys;
              fault_set = (tags[top_q] == TAG_EMPTY);
            end
            OP_REPL_PUSH: begin
              done_nxt  = 1'b0;
              wr_en     = 1'b1;
              wr_phys   = top_q;
              latch_b   = 1'b1;
              state_nxt = ST_REPL2;
              if (tags[top_q] == TAG_EMPTY) begin
                wr_data   = INDEF_W;
                fault_set = 1'b1;
              end
            end
            OP_WRITE: begin
              wr_en   = 1'b1;
              wr_phys = phys_i;
            end
            OP_WRITE_POP: begin
              // With i=0 the free of the same register is applied last, so
              // the pop wins and the register ends empty.
              wr_en     = 1'b1;
              wr_phys   = phys_i;
              free_en   = 1'b1;
              free_phys = top_q;
              top_nxt   = st1_phys;
              fault_set = (tags[top_q] == TAG_EMPTY);
            end
            OP_XCH: begin
              if (tags[top_q] == TAG_EMPTY || tags[phys_i] == TAG_EMPTY) begin
                fault_set = 1'b1;
              end else begin
                xch_en = 1'b1;
              end
            end
            OP_FREE: begin
              free_en   = 1'b1;
              free_phys = phys_i;
            end
            OP_INIT: begin
              init_en = 1'b1;
              top_nxt = '0;
            end
            OP_INC_TOP: begin
              top_nxt = st1_phys;
            end
            OP_DEC_TOP: begin
              top_nxt = push_phys;
            end
            default: begin
            end
          endcase
        end
      end

      ST_REPL2: begin
        // Second half of REPL_PUSH: push the operand captured at accept.
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
        wr_en     = 1'b1;
        wr_phys   = push_phys;
        wr_data   = data_b_q;
        top_nxt   = push_phys;
        if (tags[push_phys] != TAG_EMPTY) begin
          wr_data   = INDEF_W;
          fault_set = 1'b1;
          fault_ovf = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register file data. XCH never coincides with a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        regs[wr_phys] <= wr_data;
      end
      if (xch_en) begin
        regs[top_q]  <= regs[phys_i];
        regs[phys_i] <= regs[top_q];
      end
    end
  end

  // Tags: later statements take priority, so a pop/free beats a write to
  // the same register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags[i] <= TAG_EMPTY;
      end
    end else begin
      if (init_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          tags[i] <= TAG_EMPTY;
        end
      end
      if (wr_en) begin
        tags[wr_phys] <= wr_tag;
      end
      if (xch_en) begin
        tags[top_q]  <= tags[phys_i];
        tags[phys_i] <= tags[top_q];
      end
      if (free_en) begin
        tags[free_phys] <= TAG_EMPTY;
      end
    end
  end

  // Sequencer state, pointer, handshake pulse, read port and sticky faults.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      top_q    <= '0;
      done_q   <= 1'b0;
      data_b_q <= '0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
      c1_q     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      top_q   <= top_nxt;
      done_q  <= done_nxt;
      rd_q    <= regs[rd_phys];
      if (latch_b) begin
        data_b_q <= data_b;
      end
      if (fault_set) begin
        fault_q <= 1'b1;
        c1_q    <= fault_ovf;
      end else if (clear_fault) begin
        fault_q <= 1'b0;
        c1_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    tag_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tag_word[2*i +: 2] = tags[i];
    end
  end

  assign op_ready    = (state_q == ST_IDLE);
  assign done        = done_q;
  assign rd_data     = rd_q;
  assign st0         = regs[top_q];
  assign st1         = regs[st1_phys];
  assign top         = top_q;
  assign stack_fault = fault_q;
  assign c1          = c1_q;

endmodule
